systolic_ctrl: RTL
==================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for one weight-stationary N x N PE array tile pass: loads one weight row per cycle, drives go,
//  per-row z_weight masking and activation-buffer reads, and flags skewed column outputs valid.
//  Sits between the top-level TPU FSM (start/done) and the PE array plus the weight/activation SRAMs.
//  Input/output skew registers are external; this block only times them.
// PARAMETERS
//  ARRAY_SIZE  4    N: PE rows = PE columns
//  M_MAX       256  max activation rows per pass
//  M_W         9    width of m_cfg/a_addr; must satisfy 2^M_W > M_MAX
//  K_W         3    width of k_cfg, w_addr; must satisfy 2^K_W > ARRAY_SIZE
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-low reset
//  start        in   1     1-cycle pass request; honoured only in IDLE
//  m_cfg        in   M_W   activation rows this pass, sampled on accepted start
//  k_cfg        in   K_W   valid weight rows (reduction depth), sampled on accepted start
//  busy         out  1     high in any state other than IDLE
//  done         out  1     1-cycle pulse at end of pass
//  w_rd_en      out  1     weight SRAM read strobe (1-cycle read latency)
//  w_addr       out  K_W   weight row address
//  weight_en    out  N     one-hot row load enable to PE array
//  z_weight     out  N     per-row weight force-zero
//  a_rd_en      out  1     activation SRAM read strobe (1-cycle latency)
//  a_addr       out  M_W   activation row address
//  go           out  1     array advance enable
//  out_valid    out  N     bit j: bottom-row out_down of column j valid this cycle
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; every output 0; latched m/k and counters 0.
//  States IDLE -> LOAD_W -> RUN -> DONE -> IDLE; a single counter cnt is cleared on every state entry.
//  IDLE: start=1 latches m_cfg, k_cfg. If m_cfg==0 or k_cfg==0 -> DONE, else -> LOAD_W.
//  LOAD_W: N+1 cycles, cnt=0..N.
//   - cnt<N: w_rd_en=1, w_addr=cnt.
//   - cnt>=1: weight_en=1<<(cnt-1), aligned to the SRAM data return.
//  RUN: 2N+m cycles, cnt=0..2N+m-1; go=1 throughout.
//   - cnt<m: a_rd_en=1, a_addr=cnt.
//  out_valid[j]=1 for N+1+j <= cnt <= N+j+m: 1-cycle read latency + skew + N PE register stages.
//  z_weight[i]=1 for i>=k (latched) during LOAD_W and RUN; 0 in IDLE and DONE.
//  DONE: 1 cycle; done=1; go=0 -> IDLE. busy stays 1 in DONE.
//  start while busy: ignored, no latch. start in the DONE cycle: ignored.
//  k > N: clamped to N, so no z_weight bits set.
//  m > M_MAX: clamped to M_MAX.
//  Reset mid-pass: immediate IDLE, all outputs 0, no done pulse; PE weights are left stale.
//  Counter width M_W+1 covers 2N+M_MAX without wrap; a_addr never exceeds m-1.
// CONFIGURATION
//  SYSTOLIC_CTRL_PERF_EN defined:
//   - adds output perf_cycles[31:0], reset 0.
//   - increments every cycle busy=1 and saturates at 32'hFFFF_FFFF.
//   - cleared on the cycle start is accepted.
//  Not defined: port absent; no counter logic.
// TESTING
//  1. N=4, start m=3 k=4 at cycle 0:
//     - w_rd_en cycles 1-4; weight_en 0001,0010,0100,1000 on cycles 2-5.
//     - RUN cycles 6-16; a_addr 0,1,2 on cycles 6-8.
//     - out_valid[0] cycles 11-13; out_valid[3] cycles 14-16; done at cycle 17.
//  2. m=3 k=2 -> z_weight=4'b1100 from cycle 1 through cycle 16; 0 at done.
//  3. start m=0 k=4 -> done at cycle 1; w_rd_en, a_rd_en, go never asserted.
//  4. start pulsed again during RUN -> ignored; exactly one done pulse; next start after IDLE is accepted.
//  5. rst low during RUN cycle 3 -> all outputs 0 same cycle; state IDLE after release; no done.
//  6. PERF_EN build, test 1 pass -> perf_cycles=17 after done; start clears it to 0.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for one weight-stationary N x N systolic tile pass: weight row load, run/go, skewed output valids.
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int M_MAX      = 256,
  parameter int M_W        = 9,
  parameter int K_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [M_W-1:0]        m_cfg,
  input  logic [K_W-1:0]        k_cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [K_W-1:0]        w_addr,
  output logic [ARRAY_SIZE-1:0] weight_en,
  output logic [ARRAY_SIZE-1:0] z_weight,
  output logic                  a_rd_en,
  output logic [M_W-1:0]        a_addr,
  output logic                  go,
  output logic [ARRAY_SIZE-1:0] out_valid,
  output logic [1:0]            dbg_state
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int CNT_W = M_W + 1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_N   = CNT_W'(ARRAY_SIZE);
  localparam logic [CNT_W-1:0] C_2N  = CNT_W'(2 * ARRAY_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [M_W-1:0]        r_m, w_m_nxt;
  logic [K_W-1:0]        r_k, w_k_nxt;
  logic                  w_accept;

  logic                  r_busy, r_done, r_w_rd_en, r_a_rd_en, r_go;
  logic [K_W-1:0]        r_w_addr;
  logic [M_W-1:0]        r_a_addr;
  logic [ARRAY_SIZE-1:0] r_weight_en, r_z_weight, r_out_valid;

  logic                  w_busy, w_done, w_w_rd_en, w_a_rd_en, w_go;
  logic [K_W-1:0]        w_w_addr;
  logic [M_W-1:0]        w_a_addr;
  logic [ARRAY_SIZE-1:0] w_weight_en, w_z_weight, w_out_valid;

  // Next state, counter and latched config.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && start;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + C_ONE;
    w_m_nxt     = r_m;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_m_nxt     = (m_cfg > M_W'(M_MAX)) ? M_W'(M_MAX) : m_cfg;
          w_k_nxt     = (k_cfg > K_W'(ARRAY_SIZE)) ? K_W'(ARRAY_SIZE) : k_cfg;
          w_state_nxt = ((m_cfg == '0) || (k_cfg == '0)) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (r_cnt == C_N) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (r_cnt == (C_2N + CNT_W'(r_m) - C_ONE)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state/count so they can be registered with the state.
  always_comb begin
    w_busy      = (w_state_nxt != S_IDLE);
    w_done      = (w_state_nxt == S_DONE);
    w_go        = (w_state_nxt == S_RUN);
    w_w_rd_en   = 1'b0;
    w_w_addr    = '0;
    w_weight_en = '0;
    w_a_rd_en   = 1'b0;
    w_a_addr    = '0;
    w_z_weight  = '0;
    w_out_valid = '0;
    if (w_state_nxt == S_LOAD_W) begin
      if (w_cnt_nxt < C_N) begin
        w_w_rd_en = 1'b1;
        w_w_addr  = w_cnt_nxt[K_W-1:0];
      end
      // SRAM data returns one cycle after the read, so row r loads at cnt=r+1.
      if (w_cnt_nxt != '0) begin
        w_weight_en = ARRAY_SIZE'(1) << (w_cnt_nxt - C_ONE);
      end
    end
    if (w_state_nxt == S_RUN) begin
      if (w_cnt_nxt < CNT_W'(w_m_nxt)) begin
        w_a_rd_en = 1'b1;
        w_a_addr  = w_cnt_nxt[M_W-1:0];
      end
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        w_out_valid[j] = (w_cnt_nxt >= (C_N + CNT_W'(j + 1))) &&
                         (w_cnt_nxt <= (C_N + CNT_W'(j) + CNT_W'(w_m_nxt)));
      end
    end
    if ((w_state_nxt == S_LOAD_W) || (w_state_nxt == S_RUN)) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        w_z_weight[i] = (K_W'(i) >= w_k_nxt);
      end
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_perf;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_m         <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_addr    <= '0;
      r_weight_en <= '0;
      r_z_weight  <= '0;
      r_a_rd_en   <= 1'b0;
      r_a_addr    <= '0;
      r_go        <= 1'b0;
      r_out_valid <= '0;
`ifdef SYSTOLIC_CTRL_PERF_EN
      r_perf      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_m         <= w_m_nxt;
      r_k         <= w_k_nxt;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_w_rd_en   <= w_w_rd_en;
      r_w_addr    <= w_w_addr;
      r_weight_en <= w_weight_en;
      r_z_weight  <= w_z_weight;
      r_a_rd_en   <= w_a_rd_en;
      r_a_addr    <= w_a_addr;
      r_go        <= w_go;
      r_out_valid <= w_out_valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
      if (w_accept) begin
        r_perf <= '0;
      end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
        r_perf <= r_perf + 32'd1;
      end
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign w_rd_en   = r_w_rd_en;
  assign w_addr    = r_w_addr;
  assign weight_en = r_weight_en;
  assign z_weight  = r_z_weight;
  assign a_rd_en   = r_a_rd_en;
  assign a_addr    = r_a_addr;
  assign go        = r_go;
  assign out_valid = r_out_valid;
  assign dbg_state = r_state;
`ifdef SYSTOLIC_CTRL_PERF_EN
  assign perf_cycles = r_perf;
`endif

endmodule
